// File: rtl/core_lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
package core_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StStore,
        StExc
    } LsuState;

    typedef enum logic [1:0] {
        CauseLoadMisaligned  = 2'd0,
        CauseStoreMisaligned = 2'd1,
        CauseIllegalFunct3   = 2'd2
    } LsuExcCause;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Assumes f3 is already known to be legal.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Execute-side request, writeback/exception results and arbiter LSU ports of core_lsu.
interface core_lsu_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic          i_valid;
    logic          i_load;
    logic          i_store;
    logic [2:0]    i_funct3;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_store_data;
    logic [4:0]    i_rd;

    logic          o_busy;
    logic          o_wb_valid;
    logic [4:0]    o_wb_rd;
    logic [DW-1:0] o_wb_data;
    logic          o_exc;
    logic [1:0]    o_exc_cause;
    logic [AW-1:0] o_exc_addr;

    logic          o_lsu_read;
    logic [AW-1:0] o_r_lsu_addr;
    logic [DW-1:0] i_r_lsu_data;

    logic          o_lsu_write;
    logic [AW-1:0] o_w_lsu_addr;
    logic [3:0]    o_w_lsu_byte_en;
    logic [DW-1:0] o_w_lsu_data;

    // The LSU itself.
    modport master (
        input  i_valid, i_load, i_store, i_funct3, i_addr, i_store_data, i_rd,
        output o_busy, o_wb_valid, o_wb_rd, o_wb_data,
        output o_exc, o_exc_cause, o_exc_addr,
        output o_lsu_read, o_r_lsu_addr,
        input  i_r_lsu_data,
        output o_lsu_write, o_w_lsu_addr, o_w_lsu_byte_en, o_w_lsu_data
    );

    // Execute stage plus the memory arbiter.
    modport slave (
        output i_valid, i_load, i_store, i_funct3, i_addr, i_store_data, i_rd,
        input  o_busy, o_wb_valid, o_wb_rd, o_wb_data,
        input  o_exc, o_exc_cause, o_exc_addr,
        input  o_lsu_read, o_r_lsu_addr,
        output i_r_lsu_data,
        input  o_lsu_write, o_w_lsu_addr, o_w_lsu_byte_en, o_w_lsu_data
    );

endinterface

// File: rtl/core_lsu_align.sv
// Byte-lane steering: store byte enables/replication and load extract/extend.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_data,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_load_word >> {i_offset, 3'b000};

    always_comb begin
        o_byte_en    = 4'b1111;
        o_store_data = i_store_data;
        o_load_data  = w_shifted;
        case (i_funct3)
            F3_B: begin
                o_byte_en    = 4'b0001 << i_offset;
                o_store_data = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H: begin
                o_byte_en    = 4'b0011 << i_offset;
                o_store_data = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_BU: o_load_data = {24'h000000, w_shifted[7:0]};
            F3_HU: o_load_data = {16'h0000, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one memory op at a time from execute, word-aligned arbiter requests,
// fixed-latency load return with extraction/extension, and exception pulses.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_en,
    core_lsu_if.master bus
);

    localparam int unsigned CW = $clog2(READ_LATENCY + 1);

    LsuState       r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;

    logic [AW-1:0] r_addr;
    logic [2:0]    r_funct3;
    logic [4:0]    r_rd;
    logic [DW-1:0] r_store_data;
    logic          w_latch;

    logic          r_busy, w_busy_d;
    logic          r_wb_valid, w_wb_valid_d;
    logic [4:0]    r_wb_rd, w_wb_rd_d;
    logic [DW-1:0] r_wb_data, w_wb_data_d;
    logic          r_exc, w_exc_d;
    LsuExcCause    r_exc_cause, w_exc_cause_d;
    logic [AW-1:0] r_exc_addr, w_exc_addr_d;
    logic          r_lsu_read, w_lsu_read_d;
    logic [AW-1:0] r_r_addr, w_r_addr_d;
    logic          r_lsu_write, w_lsu_write_d;
    logic [AW-1:0] r_w_addr, w_w_addr_d;
    logic [3:0]    r_byte_en, w_byte_en_d;
    logic [DW-1:0] r_w_data, w_w_data_d;

    logic          w_accept;
    logic          w_idle;
    logic [AW-1:0] w_op_addr;
    logic [2:0]    w_op_funct3;
    logic [DW-1:0] w_op_sdata;
    logic [AW-1:0] w_word_addr;
    logic [3:0]    w_al_byte_en;
    logic [DW-1:0] w_al_store_data;
    logic [DW-1:0] w_al_load_data;

    assign w_idle   = (r_state == StIdle);
    assign w_accept = bus.i_valid && (bus.i_load || bus.i_store);

    // The aligner sees the live request while idle and the latched op afterwards.
    assign w_op_addr   = w_idle ? bus.i_addr       : r_addr;
    assign w_op_funct3 = w_idle ? bus.i_funct3     : r_funct3;
    assign w_op_sdata  = w_idle ? bus.i_store_data : r_store_data;
    assign w_word_addr = {w_op_addr[AW-1:2], 2'b00};

    core_lsu_align u_align (
        .i_funct3     (w_op_funct3),
        .i_offset     (w_op_addr[1:0]),
        .i_store_data (w_op_sdata),
        .i_load_word  (bus.i_r_lsu_data),
        .o_byte_en    (w_al_byte_en),
        .o_store_data (w_al_store_data),
        .o_load_data  (w_al_load_data)
    );

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_latch       = 1'b0;
        w_wb_valid_d  = 1'b0;
        w_exc_d       = 1'b0;
        w_lsu_read_d  = 1'b0;
        w_lsu_write_d = 1'b0;
        w_wb_rd_d     = r_wb_rd;
        w_wb_data_d   = r_wb_data;
        w_exc_cause_d = r_exc_cause;
        w_exc_addr_d  = r_exc_addr;
        w_r_addr_d    = r_r_addr;
        w_w_addr_d    = r_w_addr;
        w_byte_en_d   = r_byte_en;
        w_w_data_d    = r_w_data;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_latch = 1'b1;
                    if (!f3_legal(bus.i_load, bus.i_funct3)) begin
                        w_state_d     = StExc;
                        w_exc_d       = 1'b1;
                        w_exc_cause_d = CauseIllegalFunct3;
                        w_exc_addr_d  = bus.i_addr;
                    end else if (f3_misaligned(bus.i_funct3, bus.i_addr[1:0])) begin
                        w_state_d     = StExc;
                        w_exc_d       = 1'b1;
                        w_exc_cause_d = bus.i_load ? CauseLoadMisaligned : CauseStoreMisaligned;
                        w_exc_addr_d  = bus.i_addr;
                    end else if (bus.i_load) begin
                        w_state_d    = StLoad;
                        w_lsu_read_d = 1'b1;
                        w_r_addr_d   = w_word_addr;
                    end else begin
                        w_state_d     = StStore;
                        w_lsu_write_d = 1'b1;
                        w_w_addr_d    = w_word_addr;
                        w_byte_en_d   = w_al_byte_en;
                        w_w_data_d    = w_al_store_data;
                    end
                end
            end
            StLoad: begin
                w_state_d = StWait;
                w_cnt_d   = CW'(READ_LATENCY);
            end
            StWait: begin
                w_cnt_d = r_cnt - CW'(1);
                // Count 1 is the last cycle before the read data goes stale.
                if (r_cnt == CW'(1)) begin
                    w_state_d    = StIdle;
                    w_wb_valid_d = 1'b1;
                    w_wb_rd_d    = r_rd;
                    w_wb_data_d  = w_al_load_data;
                end
            end
            StStore, StExc: w_state_d = StIdle;
            default:        w_state_d = StIdle;
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_store_data <= '0;
            r_busy       <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_exc        <= 1'b0;
            r_exc_cause  <= CauseLoadMisaligned;
            r_exc_addr   <= '0;
            r_lsu_read   <= 1'b0;
            r_r_addr     <= '0;
            r_lsu_write  <= 1'b0;
            r_w_addr     <= '0;
            r_byte_en    <= '0;
            r_w_data     <= '0;
        end else if (i_clk_en) begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_latch) begin
                r_addr       <= bus.i_addr;
                r_funct3     <= bus.i_funct3;
                r_rd         <= bus.i_rd;
                r_store_data <= bus.i_store_data;
            end
            r_busy      <= w_busy_d;
            r_wb_valid  <= w_wb_valid_d;
            r_wb_rd     <= w_wb_rd_d;
            r_wb_data   <= w_wb_data_d;
            r_exc       <= w_exc_d;
            r_exc_cause <= w_exc_cause_d;
            r_exc_addr  <= w_exc_addr_d;
            r_lsu_read  <= w_lsu_read_d;
            r_r_addr    <= w_r_addr_d;
            r_lsu_write <= w_lsu_write_d;
            r_w_addr    <= w_w_addr_d;
            r_byte_en   <= w_byte_en_d;
            r_w_data    <= w_w_data_d;
        end
    end

    assign bus.o_busy          = r_busy;
    assign bus.o_wb_valid      = r_wb_valid;
    assign bus.o_wb_rd         = r_wb_rd;
    assign bus.o_wb_data       = r_wb_data;
    assign bus.o_exc           = r_exc;
    assign bus.o_exc_cause     = r_exc_cause;
    assign bus.o_exc_addr      = r_exc_addr;
    assign bus.o_lsu_read      = r_lsu_read;
    assign bus.o_r_lsu_addr    = r_r_addr;
    assign bus.o_lsu_write     = r_lsu_write;
    assign bus.o_w_lsu_addr    = r_w_addr;
    assign bus.o_w_lsu_byte_en = r_byte_en;
    assign bus.o_w_lsu_data    = r_w_data;

endmodule
